if_fetch_unit: RTL and testbench

- Instruction-fetch initiator for the 5-stage MIPS pipeline. It is the requesting side of the combinational instruction-memory read port.
- Owns the PC register and computes next-PC from sequential, redirect, exception and ERET sources.
- Presents the fetch address to the instruction memory and captures the returned word into the IF/ID pipeline register.
- Detects fetch address errors (AdEL) before they reach decode.

---
 rtl/mips_defs_pkg.sv | 15 +
 rtl/if_id_reg.sv | 47 ++++
 rtl/if_fetch_unit.sv | 116 +++++++++++
 tb/tb_if_fetch_unit.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_defs_pkg.sv
// Shared MIPS pipeline definitions: reset/handler vectors, exception codes, NOP word.
package mips_defs;

    localparam logic [31:0] RESET_PC   = 32'h0000_3000;
    localparam logic [31:0] HANDLER_PC = 32'h0000_4180;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with flush (highest after reset), load and hold controls.
module if_id_reg #(
    parameter logic [31:0] RESET_PC = mips_defs::RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    input  logic        load,
    input  logic [31:0] d_pc,
    input  logic [31:0] d_instr,
    input  logic        d_valid,
    input  logic        d_exc,
    input  logic [4:0]  d_exccode,
    output logic [31:0] q_pc,
    output logic [31:0] q_instr,
    output logic        q_valid,
    output logic        q_exc,
    output logic [4:0]  q_exccode
);

    import mips_defs::*;

    // Register update: reset, then flush to a bubble, then load, else hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_pc      <= RESET_PC;
            q_instr   <= NOP_WORD;
            q_valid   <= 1'b0;
            q_exc     <= 1'b0;
            q_exccode <= EXC_INT;
        end else if (flush) begin
            q_pc      <= flush_pc;
            q_instr   <= NOP_WORD;
            q_valid   <= 1'b0;
            q_exc     <= 1'b0;
            q_exccode <= EXC_INT;
        end else if (load) begin
            q_pc      <= d_pc;
            q_instr   <= d_instr;
            q_valid   <= d_valid;
            q_exc     <= d_exc;
            q_exccode <= d_exccode;
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch unit: PC register, next-PC selection, AdEL detection, IF/ID capture.
// Optional performance counters are enabled with the FETCH_PERF_CNT_EN macro.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC   = mips_defs::RESET_PC,
    parameter logic [31:0] HANDLER_PC = mips_defs::HANDLER_PC,
    parameter logic [31:0] IM_BASE    = 32'h0000_3000,
    parameter int unsigned IM_WORDS   = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_addr,
    input  logic        exc_req,
    input  logic        eret_req,
    input  logic [31:0] epc,
    output logic [31:0] im_addr,
    input  logic [31:0] im_rdata,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        if_valid,
    output logic        if_exc,
    output logic [4:0]  if_exccode
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch,
    output logic [31:0] perf_stall
`endif
);

    import mips_defs::*;

    localparam logic [31:0] IM_LAST = IM_BASE + 32'(4 * IM_WORDS) - 32'd4;

    logic [31:0] pc;
    logic [31:0] pc_next;
    logic        fetch_err;
    logic        flush;
    logic [31:0] flush_pc;
    logic        load;
    logic [31:0] fetch_instr;
    logic [4:0]  fetch_code;

    // Fetch address check: misaligned or outside the instruction memory window.
    always_comb begin
        fetch_err = (pc[1:0] != 2'b00) || (pc < IM_BASE) || (pc > IM_LAST);
    end

    // Next-PC priority: exception, ERET, stall hold, redirect, sequential.
    always_comb begin
        pc_next = pc + 32'd4;
        if (exc_req)
            pc_next = HANDLER_PC;
        else if (eret_req)
            pc_next = epc;
        else if (stall)
            pc_next = pc;
        else if (redirect_valid)
            pc_next = redirect_addr;
    end

    // IF/ID control and captured data; a faulting fetch drops the memory word.
    always_comb begin
        flush       = exc_req | eret_req;
        flush_pc    = exc_req ? HANDLER_PC : epc;
        load        = !stall;
        fetch_instr = fetch_err ? NOP_WORD : im_rdata;
        fetch_code  = fetch_err ? EXC_ADEL : EXC_INT;
    end

    // PC register.
    always_ff @(posedge clk) begin
        if (reset)
            pc <= RESET_PC;
        else
            pc <= pc_next;
    end

    assign im_addr = pc;

    if_id_reg #(
        .RESET_PC (RESET_PC)
    ) u_if_id (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .flush_pc  (flush_pc),
        .load      (load),
        .d_pc      (pc),
        .d_instr   (fetch_instr),
        .d_valid   (1'b1),
        .d_exc     (fetch_err),
        .d_exccode (fetch_code),
        .q_pc      (if_pc),
        .q_instr   (if_instr),
        .q_valid   (if_valid),
        .q_exc     (if_exc),
        .q_exccode (if_exccode)
    );

`ifdef FETCH_PERF_CNT_EN
    // Counters: valid IF/ID loads and stall cycles not overridden by exc/ERET.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetch <= '0;
            perf_stall <= '0;
        end else begin
            if (!flush && load)
                perf_fetch <= perf_fetch + 32'd1;
            if (!flush && stall)
                perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Table-driven bench for if_fetch_unit with a queue scoreboard of expected IF/ID state.
module tb_if_fetch_unit;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        redir;
        logic [31:0] raddr;
        logic        exc;
        logic        eret;
        logic [31:0] epc;
        logic [31:0] e_addr;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic        e_valid;
        logic        e_exc;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        valid;
        logic        exc;
        logic [4:0]  code;
        logic [31:0] pf;
        logic [31:0] ps;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_addr;
    logic        exc_req;
    logic        eret_req;
    logic [31:0] epc;
    logic [31:0] im_addr;
    logic [31:0] im_rdata;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_valid;
    logic        if_exc;
    logic [4:0]  if_exccode;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch;
    logic [31:0] perf_stall;
`endif

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];
    logic [31:0] m_pf = '0;
    logic [31:0] m_ps = '0;
    vec_t tbl[25];

    always #5 clk = ~clk;

    if_fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .exc_req        (exc_req),
        .eret_req       (eret_req),
        .epc            (epc),
        .im_addr        (im_addr),
        .im_rdata       (im_rdata),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .if_valid       (if_valid),
        .if_exc         (if_exc),
        .if_exccode     (if_exccode)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetch     (perf_fetch),
        .perf_stall     (perf_stall)
`endif
    );

    // Instruction memory image: two fixed words, elsewhere DEAD_xxxx tagged by address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_3000: mem_word = 32'h1111_1111;
            32'h0000_3004: mem_word = 32'h2222_2222;
            default:       mem_word = 32'hDEAD_0000 | {16'h0000, a[15:0]};
        endcase
    endfunction

    assign im_rdata = mem_word(im_addr);

    function automatic vec_t mk(input logic rst, input logic st, input logic rd,
                                input logic [31:0] ra, input logic ex, input logic er,
                                input logic [31:0] ep, input logic [31:0] ea,
                                input logic [31:0] ep_c, input logic [31:0] ei,
                                input logic ev, input logic ee);
        vec_t v;
        v.rst = rst; v.stall = st; v.redir = rd; v.raddr = ra; v.exc = ex;
        v.eret = er; v.epc = ep; v.e_addr = ea; v.e_pc = ep_c; v.e_instr = ei;
        v.e_valid = ev; v.e_exc = ee;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    // Drive one cycle of stimulus, push its expectation, compare after the edge.
    task automatic step(input vec_t v, input string tag);
        exp_t e;
        exp_t g;
        @(negedge clk);
        reset          = v.rst;
        stall          = v.stall;
        redirect_valid = v.redir;
        redirect_addr  = v.raddr;
        exc_req        = v.exc;
        eret_req       = v.eret;
        epc            = v.epc;
        if (v.rst) begin
            m_pf = '0;
            m_ps = '0;
        end else if (!(v.exc || v.eret)) begin
            if (v.stall) m_ps = m_ps + 32'd1;
            else         m_pf = m_pf + 32'd1;
        end
        e.addr  = v.e_addr;
        e.pc    = v.e_pc;
        e.instr = v.e_instr;
        e.valid = v.e_valid;
        e.exc   = v.e_exc;
        e.code  = v.e_exc ? 5'd4 : 5'd0;
        e.pf    = m_pf;
        e.ps    = m_ps;
        sb.push_back(e);
        @(posedge clk);
        #1;
        g = sb.pop_front();
        check({tag, ".im_addr"},  im_addr,           g.addr);
        check({tag, ".if_pc"},    if_pc,             g.pc);
        check({tag, ".if_instr"}, if_instr,          g.instr);
        check({tag, ".if_valid"}, {31'd0, if_valid}, {31'd0, g.valid});
        check({tag, ".if_exc"},   {31'd0, if_exc},   {31'd0, g.exc});
        check({tag, ".exccode"},  {27'd0, if_exccode}, {27'd0, g.code});
`ifdef FETCH_PERF_CNT_EN
        check({tag, ".perf_fetch"}, perf_fetch, g.pf);
        check({tag, ".perf_stall"}, perf_stall, g.ps);
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        //            rst st rd raddr          ex er epc            addr           pc             instr          v  e
        tbl[0]  = mk(0, 0, 0, 32'h0,         0, 0, 32'h0,         32'h0000_3004, 32'h0000_3000, 32'h1111_1111, 1, 0);
        tbl[1]  = mk(0, 0, 0, 32'h0,         0, 0, 32'h0,         32'h0000_3008, 32'h0000_3004, 32'h2222_2222, 1, 0);
        tbl[2]  = mk(0, 0, 1, 32'h0000_3100, 0, 0, 32'h0,         32'h0000_3100, 32'h0000_3008, 32'hDEAD_3008, 1, 0);
        tbl[3]  = mk(0, 0, 0, 32'h0,         0, 0, 32'h0,         32'h0000_3104, 32'h0000_3100, 32'hDEAD_3100, 1, 0);
        tbl[4]  = mk(0, 1, 1, 32'h0000_3200, 0, 0, 32'h0,         32'h0000_3104, 32'h0000_3100, 32'hDEAD_3100, 1, 0);
        tbl[5]  = mk(0, 1, 1, 32'h0000_3200, 0, 0, 32'h0,         32'h0000_3104, 32'h0000_3100, 32'hDEAD_3100, 1, 0);
        tbl[6]  = mk(0, 1, 1, 32'h0000_3200, 0, 0, 32'h0,         32'h0000_3104, 32'h0000_3100, 32'hDEAD_3100, 1, 0);
        tbl[7]  = mk(0, 0, 0, 32'h0,         0, 0, 32'h0,         32'h0000_3108, 32'h0000_3104, 32'hDEAD_3104, 1, 0);
        tbl[8]  = mk(0, 1, 0, 32'h0,         1, 1, 32'h0000_3024, 32'h0000_4180, 32'h0000_4180, 32'h0,         0, 0);
        tbl[9]  = mk(0, 0, 0, 32'h0,         0, 0, 32'h0,         32'h0000_4184, 32'h0000_4180, 32'hDEAD_4180, 1, 0);
        tbl[10] = mk(0, 0, 0, 32'h0,         0, 1, 32'h0000_3024, 32'h0000_3024, 32'h0000_3024, 32'h0,         0, 0);
        tbl[11] = mk(0, 0, 0, 32'h0,         0, 0, 32'h0,         32'h0000_3028, 32'h0000_3024, 32'hDEAD_3024, 1, 0);
        tbl[12] = mk(0, 0, 1, 32'h0000_3002, 0, 0, 32'h0,         32'h0000_3002, 32'h0000_3028, 32'hDEAD_3028, 1, 0);
        tbl[13] = mk(0, 0, 1, 32'h0000_7000, 0, 0, 32'h0,         32'h0000_7000, 32'h0000_3002, 32'h0,         1, 1);
        tbl[14] = mk(0, 0, 0, 32'h0,         0, 0, 32'h0,         32'h0000_7004, 32'h0000_7000, 32'h0,         1, 1);
        tbl[15] = mk(0, 0, 1, 32'h0000_6FFC, 0, 0, 32'h0,         32'h0000_6FFC, 32'h0000_7004, 32'h0,         1, 1);
        tbl[16] = mk(0, 0, 0, 32'h0,         0, 0, 32'h0,         32'h0000_7000, 32'h0000_6FFC, 32'hDEAD_6FFC, 1, 0);
        tbl[17] = mk(0, 0, 1, 32'h0000_2FFC, 0, 0, 32'h0,         32'h0000_2FFC, 32'h0000_7000, 32'h0,         1, 1);
        tbl[18] = mk(0, 0, 0, 32'h0,         1, 0, 32'h0,         32'h0000_4180, 32'h0000_4180, 32'h0,         0, 0);
        tbl[19] = mk(0, 0, 0, 32'h0,         0, 0, 32'h0,         32'h0000_4184, 32'h0000_4180, 32'hDEAD_4180, 1, 0);
        tbl[20] = mk(0, 0, 1, 32'h0000_3000, 0, 0, 32'h0,         32'h0000_3000, 32'h0000_4184, 32'hDEAD_4184, 1, 0);
        tbl[21] = mk(0, 0, 0, 32'h0,         0, 0, 32'h0,         32'h0000_3004, 32'h0000_3000, 32'h1111_1111, 1, 0);
        tbl[22] = mk(0, 0, 1, 32'hFFFF_FFFC, 0, 0, 32'h0,         32'hFFFF_FFFC, 32'h0000_3004, 32'h2222_2222, 1, 0);
        tbl[23] = mk(0, 0, 0, 32'h0,         0, 0, 32'h0,         32'h0000_0000, 32'hFFFF_FFFC, 32'h0,         1, 1);
        tbl[24] = mk(0, 0, 0, 32'h0,         0, 0, 32'h0,         32'h0000_0004, 32'h0000_0000, 32'h0,         1, 1);

        reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_addr = '0;
        exc_req = 1'b0; eret_req = 1'b0; epc = '0;

        step(mk(1, 0, 0, 32'h0, 0, 0, 32'h0, 32'h0000_3000, 32'h0000_3000, 32'h0, 0, 0), "reset0");
        step(mk(1, 0, 0, 32'h0, 0, 0, 32'h0, 32'h0000_3000, 32'h0000_3000, 32'h0, 0, 0), "reset1");

        for (int i = 0; i < 25; i++)
            step(tbl[i], $sformatf("row%0d", i));

        // Stall holding a faulting entry, then reset asserted mid-stall and mid-redirect.
        step(mk(0, 1, 0, 32'h0,         0, 0, 32'h0, 32'h0000_0004, 32'h0000_0000, 32'h0,         1, 1), "stall_err");
        step(mk(1, 1, 1, 32'h0000_3100, 0, 0, 32'h0, 32'h0000_3000, 32'h0000_3000, 32'h0,         0, 0), "rst_stall");
        step(mk(1, 0, 1, 32'h0000_3100, 0, 0, 32'h0, 32'h0000_3000, 32'h0000_3000, 32'h0,         0, 0), "rst_redir");
        step(mk(0, 0, 0, 32'h0,         0, 0, 32'h0, 32'h0000_3004, 32'h0000_3000, 32'h1111_1111, 1, 0), "rst_release");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
